// File: rtl/lstm_pkg.sv
// Shared definitions for the sequential LSTM layer and its cell core.
//   fsm_state_e      : controller state encoding
//   CELL_LAT_DEFAULT : default issue-to-result latency of the cell core
//   idx_width()      : bit width of a cell index (minimum 1)
package lstm_pkg;

    typedef enum logic [2:0] {
        FSM_IDLE  = 3'd0,
        FSM_ISSUE = 3'd1,
        FSM_WAIT  = 3'd2,
        FSM_WRITE = 3'd3,
        FSM_OUT   = 3'd4
    } fsm_state_e;

    localparam int CELL_LAT_DEFAULT = 2;

    function automatic int idx_width(input int num_cells);
        return (num_cells > 1) ? $clog2(num_cells) : 1;
    endfunction

endpackage

// File: rtl/lstm_seq_layer_if.sv
// Timestep handshake bundle between a producer/consumer and lstm_seq_layer.
//   in_valid / in_ready / x_t / seq_first : timestep offer (producer -> layer)
//   out_valid / out_ready / h_t / out_step : result (layer -> consumer)
// master: the producer/consumer side; slave: the layer.
interface lstm_seq_layer_if #(
    parameter int INPUT_SIZE  = 128,
    parameter int HIDDEN_SIZE = 64
);
    logic                   in_valid;
    logic                   in_ready;
    logic [INPUT_SIZE-1:0]  x_t;
    logic                   seq_first;
    logic                   out_valid;
    logic                   out_ready;
    logic [HIDDEN_SIZE-1:0] h_t;
    logic [15:0]            out_step;

    modport master (
        output in_valid, x_t, seq_first, out_ready,
        input  in_ready, out_valid, h_t, out_step
    );

    modport slave (
        input  in_valid, x_t, seq_first, out_ready,
        output in_ready, out_valid, h_t, out_step
    );
endinterface

// File: rtl/lstm_cell_core.sv
// Time-multiplexed LSTM cell core, shared by all cells of the layer.
// An issue pulse captures (x, h_prev, c_prev); res_valid/h_out/c_out appear
// exactly CELL_LAT cycles later. This build carries the reference arithmetic
// (h_out = h_prev + zero-extended x, c_out = c_prev + 1); the per-cell weight
// bank (file WEIGHT_FILE_PREFIX + "cell<k>") is selected by cell_idx.
//   clk, reset_n          : clock, async active-low reset (flushes the pipe)
//   issue, cell_idx       : start a cell evaluation for cell cell_idx
//   x, h_prev, c_prev     : cell operands
//   res_valid, h_out, c_out : result, valid for one cycle
module lstm_cell_core
    import lstm_pkg::*;
#(
    parameter int    N                  = 8,
    parameter int    HIDDEN_SIZE        = 64,
    parameter int    NUM_CELLS          = 4,
    parameter int    CELL_LAT           = CELL_LAT_DEFAULT,
    parameter string WEIGHT_FILE_PREFIX = "weights/lstm_"
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          issue,
    input  logic [idx_width(NUM_CELLS)-1:0] cell_idx,
    input  logic [N-1:0]                  x,
    input  logic [HIDDEN_SIZE-1:0]        h_prev,
    input  logic [HIDDEN_SIZE-1:0]        c_prev,
    output logic                          res_valid,
    output logic [HIDDEN_SIZE-1:0]        h_out,
    output logic [HIDDEN_SIZE-1:0]        c_out
);

    // The reference arithmetic is weight-independent, so the bank select and
    // file prefix are carried but not consumed here.
    localparam bit unused_has_weights = (WEIGHT_FILE_PREFIX != "");
    logic unused_cell_idx;
    assign unused_cell_idx = ^cell_idx;

    logic [HIDDEN_SIZE-1:0] h_calc;
    logic [HIDDEN_SIZE-1:0] c_calc;

    assign h_calc = h_prev + HIDDEN_SIZE'(x);
    assign c_calc = c_prev + HIDDEN_SIZE'(1);

    logic                   vld_p [CELL_LAT];
    logic [HIDDEN_SIZE-1:0] h_p   [CELL_LAT];
    logic [HIDDEN_SIZE-1:0] c_p   [CELL_LAT];

    // Stage 0 captures the issued operands' result; stages 1..CELL_LAT-1 delay it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CELL_LAT; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < CELL_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        h_p[0] <= h_calc;
        c_p[0] <= c_calc;
        for (int i = 1; i < CELL_LAT; i++) begin
            h_p[i] <= h_p[i-1];
            c_p[i] <= c_p[i-1];
        end
    end

    assign res_valid = vld_p[CELL_LAT-1];
    assign h_out     = h_p[CELL_LAT-1];
    assign c_out     = c_p[CELL_LAT-1];

endmodule

// File: rtl/lstm_seq_layer.sv
// Sequential LSTM layer: one timestep at a time, NUM_CELLS cells evaluated
// one after another on a single shared lstm_cell_core.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : timestep in (in_valid/in_ready/x_t/seq_first) and
//                  result out (out_valid/out_ready/h_t/out_step)
// RECURRENT=0 chains cells within a timestep; RECURRENT=1 feeds each cell
// its own state from the previous timestep.
module lstm_seq_layer
    import lstm_pkg::*;
#(
    parameter int    N                  = 8,
    parameter int    INPUT_SIZE         = 128,
    parameter int    HIDDEN_SIZE        = 64,
    parameter int    NUM_CELLS          = 4,
    parameter int    CELL_LAT           = CELL_LAT_DEFAULT,
    parameter int    RECURRENT          = 1,
    parameter string WEIGHT_FILE_PREFIX = "weights/lstm_"
) (
    input  logic              clk,
    input  logic              reset_n,
    lstm_seq_layer_if.slave   bus
);

    localparam logic [2:0] S_IDLE  = FSM_IDLE;
    localparam logic [2:0] S_ISSUE = FSM_ISSUE;
    localparam logic [2:0] S_WAIT  = FSM_WAIT;
    localparam logic [2:0] S_WRITE = FSM_WRITE;
    localparam logic [2:0] S_OUT   = FSM_OUT;

    localparam int KW        = idx_width(NUM_CELLS);
    localparam int XW        = NUM_CELLS * N;
    localparam int WCW       = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;
    localparam int WAIT_LOAD = (CELL_LAT > 1) ? CELL_LAT - 2 : 0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [2:0]             state;
    logic [KW-1:0]          k;
    logic [WCW-1:0]         wait_cnt;
    logic                   first_lat;
    logic                   have_prev;
    logic [XW-1:0]          x_lat;
    logic [HIDDEN_SIZE-1:0] mem_h [NUM_CELLS];
    logic [HIDDEN_SIZE-1:0] mem_c [NUM_CELLS];
    logic                   out_valid_r;
    logic [HIDDEN_SIZE-1:0] h_t_r;
    logic [15:0]            out_step_r;

    logic                   issue;
    logic [N-1:0]           x_cell;
    logic [HIDDEN_SIZE-1:0] h_prev;
    logic [HIDDEN_SIZE-1:0] c_prev;
    logic                   res_valid;
    logic [HIDDEN_SIZE-1:0] h_out;
    logic [HIDDEN_SIZE-1:0] c_out;
    logic                   accept;
    logic                   wr_en;

    // Bits of x_t above the last cell's slice are never consumed.
    logic unused_x_t;
    assign unused_x_t = ^bus.x_t;

    assign accept = (state == S_IDLE) && bus.in_valid;
    assign issue  = (state == S_ISSUE);
    assign wr_en  = (state == S_WRITE) && res_valid;
    assign x_cell = x_lat[int'(k)*N +: N];

    always_comb begin
        h_prev = '0;
        c_prev = '0;
        if (RECURRENT != 0) begin
            if (!first_lat) begin
                h_prev = mem_h[k];
                c_prev = mem_c[k];
            end
        end else begin
            if (k != '0) begin
                h_prev = mem_h[k - KW'(1)];
                c_prev = mem_c[k - KW'(1)];
            end
        end
    end

    lstm_cell_core #(
        .N                  (N),
        .HIDDEN_SIZE        (HIDDEN_SIZE),
        .NUM_CELLS          (NUM_CELLS),
        .CELL_LAT           (CELL_LAT),
        .WEIGHT_FILE_PREFIX (WEIGHT_FILE_PREFIX)
    ) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .issue     (issue),
        .cell_idx  (k),
        .x         (x_cell),
        .h_prev    (h_prev),
        .c_prev    (c_prev),
        .res_valid (res_valid),
        .h_out     (h_out),
        .c_out     (c_out)
    );

    always_ff @(posedge clk) begin
        if (accept) x_lat <= bus.x_t[XW-1:0];
    end

    // WAIT is timed by a counter so that WRITE lands exactly on the res_valid
    // cycle; WRITE still waits on res_valid. OUT spends one cycle latching h_t
    // and out_step before raising out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            k           <= '0;
            wait_cnt    <= '0;
            first_lat   <= 1'b1;
            have_prev   <= 1'b0;
            out_valid_r <= 1'b0;
            h_t_r       <= '0;
            out_step_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        k         <= '0;
                        first_lat <= bus.seq_first || !have_prev;
                        have_prev <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= WCW'(WAIT_LOAD);
                    state    <= (CELL_LAT > 1) ? S_WAIT : S_WRITE;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) state <= S_WRITE;
                    else                wait_cnt <= wait_cnt - WCW'(1);
                end
                S_WRITE: begin
                    if (res_valid) begin
                        if (k == KW'(NUM_CELLS - 1)) begin
                            state <= S_OUT;
                        end else begin
                            k     <= k + KW'(1);
                            state <= S_ISSUE;
                        end
                    end
                end
                S_OUT: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        h_t_r       <= mem_h[NUM_CELLS-1];
                        out_step_r  <= first_lat ? 16'h0000 : sat_inc16(out_step_r);
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                mem_h[i] <= '0;
                mem_c[i] <= '0;
            end
        end else if (wr_en) begin
            mem_h[k] <= h_out;
            mem_c[k] <= c_out;
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.h_t       = h_t_r;
    assign bus.out_step  = out_step_r;

endmodule

// File: tb/tb_lstm_seq_layer.sv
// Directed bench for lstm_seq_layer: one chained instance (RECURRENT=0) and
// one recurrent instance (RECURRENT=1), N=8, HIDDEN_SIZE=16, NUM_CELLS=4,
// CELL_LAT=2, with the reference-arithmetic core.
module tb_lstm_seq_layer;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    lstm_seq_layer_if #(.INPUT_SIZE(32), .HIDDEN_SIZE(16)) bus_c ();
    lstm_seq_layer_if #(.INPUT_SIZE(32), .HIDDEN_SIZE(16)) bus_r ();

    lstm_seq_layer #(
        .N(8), .INPUT_SIZE(32), .HIDDEN_SIZE(16), .NUM_CELLS(4),
        .CELL_LAT(2), .RECURRENT(0), .WEIGHT_FILE_PREFIX("weights/lstm_")
    ) u_chain (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus_c)
    );

    lstm_seq_layer #(
        .N(8), .INPUT_SIZE(32), .HIDDEN_SIZE(16), .NUM_CELLS(4),
        .CELL_LAT(2), .RECURRENT(1), .WEIGHT_FILE_PREFIX("weights/lstm_")
    ) u_rec (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic drive_in(input bit rec, input bit v, input logic [31:0] x, input bit f);
        if (rec) begin
            bus_r.in_valid = v; bus_r.x_t = x; bus_r.seq_first = f;
        end else begin
            bus_c.in_valid = v; bus_c.x_t = x; bus_c.seq_first = f;
        end
    endtask

    task automatic set_ready(input bit rec, input bit r);
        if (rec) bus_r.out_ready = r;
        else     bus_c.out_ready = r;
    endtask

    // Offers one timestep, waits (bounded) for out_valid, captures the result
    // and completes the output handshake. Returns one cycle after the handshake.
    task automatic do_step(input bit rec, input logic [31:0] x, input bit first,
                           output int lat, output logic [15:0] h, output logic [15:0] st);
        bit got;
        got = 1'b0;
        lat = -1;
        h   = 16'hDEAD;
        st  = 16'hDEAD;
        drive_in(rec, 1'b1, x, first);
        @(posedge clk); #1;
        drive_in(rec, 1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if ((rec ? bus_r.out_valid : bus_c.out_valid) === 1'b1) begin
                lat = i;
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            h  = rec ? bus_r.h_t : bus_c.h_t;
            st = rec ? bus_r.out_step : bus_c.out_step;
            set_ready(rec, 1'b1);
            @(posedge clk); #1;
            set_ready(rec, 1'b0);
        end
    endtask

    task automatic check_step(input string name, input int lat, input logic [15:0] h,
                              input logic [15:0] st, input logic [15:0] exp_h,
                              input logic [15:0] exp_st, input bit rec);
        n_tests++;
        if (lat !== 13) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, expected 13", name, lat);
        end
        n_tests++;
        if (h !== exp_h) begin
            n_fail++;
            $display("FAIL %s h_t: got %h, expected %h", name, h, exp_h);
        end
        n_tests++;
        if (st !== exp_st) begin
            n_fail++;
            $display("FAIL %s out_step: got %0d, expected %0d", name, st, exp_st);
        end
        n_tests++;
        if ((rec ? bus_r.in_ready : bus_c.in_ready) !== 1'b1 ||
            (rec ? bus_r.out_valid : bus_c.out_valid) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post-handshake: in_ready=%b out_valid=%b, expected 1/0", name,
                     rec ? bus_r.in_ready : bus_c.in_ready, rec ? bus_r.out_valid : bus_c.out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_in(1'b0, 1'b0, 32'h0, 1'b0);
        drive_in(1'b1, 1'b0, 32'h0, 1'b0);
        set_ready(1'b0, 1'b0);
        set_ready(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus_c.out_valid !== 1'b0 || bus_r.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset out_valid: chain=%b rec=%b, expected 0", bus_c.out_valid, bus_r.out_valid);
        end
        n_tests++;
        if (bus_c.h_t !== 16'h0 || bus_r.h_t !== 16'h0) begin
            n_fail++;
            $display("FAIL reset h_t: chain=%h rec=%h, expected 0000", bus_c.h_t, bus_r.h_t);
        end
        n_tests++;
        if (bus_c.out_step !== 16'h0 || bus_r.out_step !== 16'h0) begin
            n_fail++;
            $display("FAIL reset out_step: chain=%0d rec=%0d, expected 0", bus_c.out_step, bus_r.out_step);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus_c.in_ready !== 1'b1 || bus_r.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset in_ready: chain=%b rec=%b, expected 1", bus_c.in_ready, bus_r.in_ready);
        end
    endtask

    task automatic test_chained();
        int lat;
        logic [15:0] h, st;
        // cells: 0+1, 1+2, 3+3, 6+4 -> 0x000A
        do_step(1'b0, 32'h04030201, 1'b1, lat, h, st);
        check_step("chain_first", lat, h, st, 16'h000A, 16'd0, 1'b0);
        // no carry-over between timesteps: 1,2,3,4 -> 0x0004, step 1
        do_step(1'b0, 32'h01010101, 1'b0, lat, h, st);
        check_step("chain_second", lat, h, st, 16'h0004, 16'd1, 1'b0);
    endtask

    task automatic test_recurrent();
        int lat;
        logic [15:0] h, st;
        do_step(1'b1, 32'h04030201, 1'b1, lat, h, st);
        check_step("rec_step0", lat, h, st, 16'h0004, 16'd0, 1'b1);
        do_step(1'b1, 32'h04030201, 1'b0, lat, h, st);
        check_step("rec_step1", lat, h, st, 16'h0008, 16'd1, 1'b1);
        do_step(1'b1, 32'h04030201, 1'b0, lat, h, st);
        check_step("rec_step2", lat, h, st, 16'h000C, 16'd2, 1'b1);
    endtask

    task automatic test_seq_restart();
        int lat;
        logic [15:0] h, st;
        do_step(1'b1, 32'h09000000, 1'b1, lat, h, st);
        check_step("rec_restart", lat, h, st, 16'h0009, 16'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] h, st;
        bit got;
        got = 1'b0;
        // cell 3 state 9 + 4 -> 0x000D, step 1
        drive_in(1'b1, 1'b1, 32'h04030201, 1'b0);
        @(posedge clk); #1;
        drive_in(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (bus_r.out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL bp_out_valid: out_valid never rose, expected within 13 cycles");
        end
        // Offer a conflicting timestep while stalled; it must be ignored.
        drive_in(1'b1, 1'b1, 32'hFFFFFFFF, 1'b1);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (bus_r.out_valid !== 1'b1 || bus_r.h_t !== 16'h000D ||
                bus_r.out_step !== 16'd1 || bus_r.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b h_t=%h out_step=%0d in_ready=%b, expected 1/000d/1/0",
                         c, bus_r.out_valid, bus_r.h_t, bus_r.out_step, bus_r.in_ready);
            end
        end
        drive_in(1'b1, 1'b0, 32'h0, 1'b0);
        set_ready(1'b1, 1'b1);
        @(posedge clk); #1;
        set_ready(1'b1, 1'b0);
        n_tests++;
        if (bus_r.in_ready !== 1'b1 || bus_r.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, expected 1/0", bus_r.in_ready, bus_r.out_valid);
        end
        // Stalled seq_first had no effect: state continues, 13+4 -> 0x0011, step 2
        do_step(1'b1, 32'h04030201, 1'b0, lat, h, st);
        check_step("bp_next", lat, h, st, 16'h0011, 16'd2, 1'b1);
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [15:0] h, st;
        int seen;
        drive_in(1'b1, 1'b1, 32'h04030201, 1'b0);
        @(posedge clk); #1;
        drive_in(1'b1, 1'b0, 32'h0, 1'b0);
        // cell k occupies cycles 3k+1..3k+3 after accept; cycle 8 is WAIT of cell 2
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus_r.out_valid !== 1'b0 || bus_r.h_t !== 16'h0 || bus_r.out_step !== 16'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: out_valid=%b h_t=%h out_step=%0d, expected 0/0000/0",
                     bus_r.out_valid, bus_r.h_t, bus_r.out_step);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus_r.out_valid !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midreset_no_output: out_valid high %0d cycles, expected 0", seen);
        end
        n_tests++;
        if (bus_r.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_in_ready: got %b, expected 1", bus_r.in_ready);
        end
        // no seq_first, but first timestep after reset: zero state, step 0
        do_step(1'b1, 32'h04030201, 1'b0, lat, h, st);
        check_step("midreset_next", lat, h, st, 16'h0004, 16'd0, 1'b1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_chained();
        test_recurrent();
        test_seq_restart();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
